// File: rtl/rr_bus_sched_pkg.sv
// Shared types and constants for the round-robin bus scheduler.
package rr_bus_pkg;

   localparam int unsigned N_DEF         = 4;
   localparam int unsigned MAX_BURST_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      TURN
   } state_t;

   // Index of the set bit; result is 0 for an all-zero vector.
   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      onehot_to_idx = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((oh >> i) == 32'd1) onehot_to_idx = i;
      end
   endfunction

endpackage

// File: rtl/rr_bus_sched_if.sv
// Request/grant bundle between the requesters and the bus scheduler.
interface rr_bus_sched_if
   import rr_bus_pkg::*;
#(
   parameter int unsigned N = N_DEF
);

   logic [N-1:0]         req_in;
   logic [N-1:0]         last_in;
   logic [N-1:0]         gnt_out;
   logic [$clog2(N)-1:0] owner_out;
   logic                 busy_out;
   logic                 preempt_out;

   modport slave (
      input  req_in, last_in,
      output gnt_out, owner_out, busy_out, preempt_out
   );

   modport master (
      output req_in, last_in,
      input  gnt_out, owner_out, busy_out, preempt_out
   );

endinterface

// File: rtl/rr_bus_sched_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_pick
   import rr_bus_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         win,
   output logic                 valid
);

   localparam int unsigned IW = $clog2(N);

   logic [IW-1:0] idx;

   always_comb begin
      win   = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IW'((32'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            win[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_bus_sched.sv
// Round-robin bus scheduler: grant, bounded burst hold, one turnaround cycle.
module rr_bus_sched
   import rr_bus_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input logic           clk,
   input logic           rst,
   rr_bus_sched_if.slave bus
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   state_t        state, state_nx;
   logic [N-1:0]  gnt, gnt_nx, win;
   logic [IW-1:0] owner, owner_nx, ptr, ptr_nx, win_idx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          preempt, preempt_nx;
   logic          valid, own_last, own_req, burst_end, rel;

   rr_pick #(.N(N)) u_pick (
      .req   (bus.req_in),
      .ptr   (ptr),
      .win   (win),
      .valid (valid)
   );

   assign win_idx = IW'(onehot_to_idx(32'(win)));

   // cnt holds completed owned cycles, so the current cycle is cnt+1.
   assign own_last  = bus.last_in[owner];
   assign own_req   = bus.req_in[owner];
   assign burst_end = (cnt == CW'(MAX_BURST - 1));
   assign rel       = own_last || !own_req || burst_end;

   always_comb begin
      state_nx   = state;
      gnt_nx     = gnt;
      owner_nx   = owner;
      ptr_nx     = ptr;
      cnt_nx     = cnt;
      preempt_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (valid) begin
               state_nx = OWN;
               gnt_nx   = win;
               owner_nx = win_idx;
               cnt_nx   = '0;
               ptr_nx   = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
            end
         end
         OWN: begin
            if (rel) begin
               state_nx   = TURN;
               gnt_nx     = '0;
               preempt_nx = burst_end && own_req && !own_last;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         TURN: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         owner   <= '0;
         ptr     <= '0;
         cnt     <= '0;
         preempt <= 1'b0;
      end else begin
         state   <= state_nx;
         gnt     <= gnt_nx;
         owner   <= owner_nx;
         ptr     <= ptr_nx;
         cnt     <= cnt_nx;
         preempt <= preempt_nx;
      end
   end

   assign bus.gnt_out     = gnt;
   assign bus.owner_out   = owner;
   assign bus.busy_out    = |gnt;
   assign bus.preempt_out = preempt;

endmodule

// File: doc/rr_bus_sched.md
# rr_bus_sched

Round-robin scheduler that shares one bus between 4 requesters using a grant/hold/release handshake. The owner keeps the bus for a burst of up to MAX_BURST cycles, then a turnaround cycle follows. Rotating priority starts just after the last owner. It sits in front of the shared memory/peripheral bus and drives the bus mux select and per-requester grants.

## Interface
- N, 4, number of requesters (design and verification target is 4)
- MAX_BURST, 8, maximum cycles one owner may hold the bus (2..255)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-high
- req_in  in  N  request per requester; level, held while bus is wanted
- last_in  in  N  requester i marks its final bus cycle; used only when i is owner
- gnt_out  out  N  one-hot grant (or zero); registered
- owner_out  out  $clog2(N)  index of current owner, valid when busy_out=1
- busy_out  out  1  bus owned this cycle (equals |gnt_out)
- preempt_out  out  1  one-cycle pulse when an owner is forcibly released at MAX_BURST

## Operation
- State machine (registered) with three states: IDLE, OWN, TURN.
- IDLE: if req_in != 0, pick the winner with rotating priority and go to OWN with gnt_out = onehot(winner). Stay in IDLE otherwise.
- Rotating priority: search order is ptr, ptr+1, … mod N. After a grant to i, ptr becomes (i+1) mod N. Reset value of ptr is 0, so requester 0 has top priority first.
- OWN: burst counter cnt counts owned cycles, from 1 to MAX_BURST. The owner is released when any of these holds:
  - last_in[owner]=1
  - req_in[owner]=0 (release takes effect in that same cycle's next edge)
  - cnt==MAX_BURST
- On release: gnt_out→0 and the state goes to TURN.
- preempt_out=1 for one cycle only when the release is caused by cnt==MAX_BURST and last_in[owner]=0 and req_in[owner]=1.
- TURN: exactly one idle cycle with no grant, then IDLE. New arbitration happens in IDLE.
- Non-owner last_in bits are ignored. Requests arriving during OWN/TURN wait; there is no queueing beyond req_in level.
- cnt width is $clog2(MAX_BURST+1). cnt resets to 0 on every new grant and never wraps past MAX_BURST.

## Timing
- Reset values: gnt_out=0, owner_out=0, busy_out=0, preempt_out=0, state=IDLE, ptr=0, cnt=0.
- Grant latency: req sampled in IDLE at edge k, so gnt_out is high after edge k (1 cycle).
- Minimum hold: 1 cycle. If last_in is asserted in the first owned cycle, the bus is released at the next edge.
- Maximum hold: MAX_BURST cycles.
- Re-grant gap: release edge → TURN → IDLE → grant, i.e. 2 idle cycles between back-to-back owners (busy_out low for 2 cycles).
- A continuous single requester with MAX_BURST=8 gets 8 cycles on, 2 off, repeating, with preempt_out pulsing at each release.
- Simultaneous last_in and cnt==MAX_BURST: normal release, no preempt pulse.
- Reset asserted mid-burst: all outputs go to 0 immediately (asynchronous). After release the block arbitrates from ptr=0.
- preempt_out is coincident with the first TURN cycle.

## Structure
- Package rr_bus_pkg holds:
  - state enum (IDLE, OWN, TURN)
  - default N and MAX_BURST constants
  - the function to convert one-hot to index
- One sub-module, rr_pick: combinational rotating-priority picker. Inputs are req[N] and ptr; outputs are one-hot win[N] and valid.
- The top module holds the FSM, ptr, cnt, and the output registers.

## Test plan
- Single requester: req_in=0001 held, last_in=0, MAX_BURST=8.
  - gnt_out=0001 for 8 cycles.
  - preempt_out pulses once; 2 cycles of gnt=0; then gnt=0001 again.
- All request: req_in=1111 held, each owner asserts last_in on its 3rd cycle.
  - Grants rotate 0001→0010→0100→1000→0001.
  - Each grant lasts 3 cycles with a 2-cycle gap; preempt_out never fires.
- Early drop: owner 2 deasserts req_in[2] in burst cycle 4 (MAX_BURST=8).
  - gnt_out→0 at the next edge; no preempt.
  - Next grant goes to the lowest index ≥3 that is requesting.
- Boundary: last_in[owner]=1 exactly in cycle 8 (MAX_BURST=8).
  - Release happens with preempt_out=0.
  - A non-owner last_in pulse has no effect.
- Reset mid-burst: rst pulsed while gnt_out=0100.
  - All outputs go to 0 asynchronously.
  - After reset, with req_in=1100, the first grant is 0100 (ptr=0 search order).
